fwd_hazard_ctrl: RTL and testbench
==================================

FWD_HAZARD_CTRL -- requirements
Module: fwd_hazard_ctrl

Interface
REQ-001 SHALL have parameter REG_W, default 5, meaning register-index width.
REQ-002 SHALL have parameter NSRC, default 2, meaning source operands per instruction.
REQ-003 SHALL have parameter NSTAGE, default 2, meaning forward-capable stages ahead of EX (1=MEM, 2=WB, ...); legal range 1..6.
REQ-004 SHALL have derived constant SEL_W = clog2(NSTAGE+1), minimum 1.
REQ-005 SHALL have port clk  in  1  sole clock; one clock, all state on rising edge.
REQ-006 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-007 SHALL have port id_valid  in  1  instruction in ID is real (not bubble).
REQ-008 SHALL have port id_rs  in  NSRC*REG_W  source indices of ID instruction, operand i at bits [i*REG_W +: REG_W].
REQ-009 SHALL have port id_rd  in  REG_W  destination index of ID instruction.
REQ-010 SHALL have port id_we  in  1  ID instruction writes id_rd.
REQ-011 SHALL have port id_load  in  1  ID instruction is a load (result ready only in WB).
REQ-012 SHALL have port stall_in  in  1  external freeze of ID and later stages.
REQ-013 SHALL have port flush  in  1  kill ID instruction at this edge.
REQ-014 SHALL have port fwd_sel  out  NSRC*SEL_W  registered forward select for the instruction now in EX; 0=register file, k=stage k ahead of EX.
REQ-015 SHALL have port stall_out  out  1  combinational load-use stall request to fetch/ID.
REQ-016 SHALL have port stall_cnt  out  16  saturating count of load-use stall cycles.

Function
REQ-017 SHALL keep an in-flight table ent[1..NSTAGE], each {v, we, load, rd}; ent[1] = instruction in EX, ent[k] = k stages ahead of ID.
REQ-018 SHALL define match(k,i) = ent[k].v & ent[k].we & ent[k].rd==rs_i & rs_i!=0.
REQ-019 SHALL assert stall_out when id_valid & !flush & any i has match(1,i) & ent[1].load; register 0 never causes a stall.
REQ-020 SHALL compute, per operand, sel_i = smallest k with match(k,i) (youngest producer wins), else 0.
REQ-021 SHALL, on an edge with stall_in=1, hold ent[], fwd_sel and stall_cnt unchanged (stall_in overrides stall_out and flush).
REQ-022 SHALL, on an edge with stall_in=0 and stall_out=1, shift ent[k+1]<=ent[k], load ent[1] with v=0, set fwd_sel to 0, increment stall_cnt.
REQ-023 SHALL, on an edge with stall_in=0, stall_out=0, shift ent[k+1]<=ent[k], load ent[1]<={id_valid & !flush, id_we, id_load, id_rd}, set fwd_sel to sel_i values.
REQ-024 SHALL write fwd_sel to 0 for any operand when the ID instruction is invalid or flushed.
REQ-025 SHALL discard ent[NSTAGE] on shift; a producer older than NSTAGE is read from the register file (sel 0).
REQ-026 SHALL saturate stall_cnt at 16'hFFFF (no wrap).
REQ-027 SHALL give forward latency of one cycle: sel computed in ID appears on fwd_sel the cycle the consumer is in EX.
REQ-028 SHALL treat id_rd=0 with id_we=1 as a legal entry that never matches.

Reset
REQ-029 SHALL, on rst=1 at an edge, clear all ent[].v, fwd_sel=0, stall_cnt=0; rst overrides stall_in and flush.
REQ-030 SHALL drive stall_out=0 in the cycle after reset (table empty).
REQ-031 SHALL let a reset mid-stall drop all in-flight entries; no stall survives reset.

Structure
REQ-032 SHALL place REG_W default, SEL_W function and in-flight entry typedef in shared package fwd_pkg.
REQ-033 SHALL use one sub-module fwd_match (per-operand priority compare over ent[], outputs sel and load-hit), instantiated NSRC times.
REQ-034 SHALL be sized for 120-400 lines of RTL total.

Verification
REQ-035 SHALL test back-to-back ALU: add r3 then sub uses r3 as rs0 -> fwd_sel[0]=1 in consumer EX cycle, no stall.
REQ-036 SHALL test distance two: r3 writer, unrelated, r3 reader -> fwd_sel[0]=2; with writer of r3 in both ent[1] and ent[2] -> sel=1.
REQ-037 SHALL test load-use: lw r5 then add uses r5 as rs1 -> stall_out=1 one cycle, stall_cnt 0->1, then fwd_sel[1]=2.
REQ-038 SHALL test register 0: writer rd=0 (lw), reader rs0=0 -> stall_out=0, fwd_sel=0.
REQ-039 SHALL test stall_in/flush: stall_in held 3 cycles during load-use -> fwd_sel and stall_cnt frozen; flush with hazard -> no stall, bubble enters ent[1].
REQ-040 SHALL test reset and saturation: rst mid-stall -> all outputs 0 next cycle; 70000 forced load-use cycles -> stall_cnt=16'hFFFF.

Source files
------------

// File: rtl/fwd_pkg.sv
// Shared sizing helpers and the in-flight entry type for the forwarding /
// load-use hazard controller.
package fwd_pkg;

  localparam int REG_W_DEF = 5;
  // Widest register index an entry can hold; REG_W must not exceed this.
  localparam int RD_MAX_W  = 16;

  typedef struct packed {
    logic                v;
    logic                we;
    logic                load;
    logic [RD_MAX_W-1:0] rd;
  } ent_t;

  function automatic int sel_w(input int nstage);
    return (nstage < 1) ? 1 : $clog2(nstage + 1);
  endfunction

endpackage

// File: rtl/fwd_match.sv
// Per-operand priority compare of one source index against the in-flight
// table: youngest matching producer wins, and a hit on EX tags a load-use.
module fwd_match
  import fwd_pkg::*;
#(
  parameter int REG_W  = REG_W_DEF,
  parameter int NSTAGE = 2,
  parameter int SEL_W  = sel_w(NSTAGE)
) (
  input  logic [REG_W-1:0] rs,
  input  ent_t             ent [NSTAGE],
  output logic [SEL_W-1:0] sel,
  output logic             load_hit
);

  logic [NSTAGE-1:0]   w_match;
  logic [RD_MAX_W-1:0] w_rs_ext;

  assign w_rs_ext = RD_MAX_W'(rs);

  generate
    for (genvar gi = 0; gi < NSTAGE; gi++) begin : g_cmp
      assign w_match[gi] = ent[gi].v & ent[gi].we &
                           (ent[gi].rd == w_rs_ext) & (rs != '0);
    end
  endgenerate

  // Scan oldest to youngest so the nearest producer overwrites older ones.
  always_comb begin
    sel = '0;
    for (int k = NSTAGE - 1; k >= 0; k--) begin
      if (w_match[k]) sel = SEL_W'(k + 1);
    end
  end

  assign load_hit = w_match[0] & ent[0].load;

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding-select and load-use stall controller: tracks producers in the
// stages ahead of ID and registers the forward selects for the EX stage.
module fwd_hazard_ctrl
  import fwd_pkg::*;
#(
  parameter int  REG_W  = REG_W_DEF,
  parameter int  NSRC   = 2,
  parameter int  NSTAGE = 2,
  localparam int SEL_W  = sel_w(NSTAGE)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    id_valid,
  input  logic [NSRC*REG_W-1:0]   id_rs,
  input  logic [REG_W-1:0]        id_rd,
  input  logic                    id_we,
  input  logic                    id_load,
  input  logic                    stall_in,
  input  logic                    flush,
  output logic [NSRC*SEL_W-1:0]   fwd_sel,
  output logic                    stall_out,
  output logic [15:0]             stall_cnt
);

  // r_ent[0] is the instruction in EX, r_ent[k] is k+1 stages ahead of ID.
  ent_t                  r_ent [NSTAGE];
  logic [NSRC*SEL_W-1:0] r_fwd_sel;
  logic [15:0]           r_stall_cnt;

  logic [NSRC*SEL_W-1:0] w_sel;
  logic [NSRC-1:0]       w_load_hit;
  logic                  w_id_live;
  logic                  w_stall;
  ent_t                  w_id_ent;

  generate
    for (genvar gi = 0; gi < NSRC; gi++) begin : g_src
      fwd_match #(
        .REG_W  (REG_W),
        .NSTAGE (NSTAGE),
        .SEL_W  (SEL_W)
      ) u_match (
        .rs       (id_rs[gi*REG_W +: REG_W]),
        .ent      (r_ent),
        .sel      (w_sel[gi*SEL_W +: SEL_W]),
        .load_hit (w_load_hit[gi])
      );
    end
  endgenerate

  assign w_id_live = id_valid & ~flush;
  assign w_stall   = w_id_live & (|w_load_hit);

  always_comb begin
    w_id_ent      = '0;
    w_id_ent.v    = w_id_live;
    w_id_ent.we   = id_we;
    w_id_ent.load = id_load;
    w_id_ent.rd   = RD_MAX_W'(id_rd);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NSTAGE; k++) r_ent[k] <= '0;
      r_fwd_sel   <= '0;
      r_stall_cnt <= '0;
    end else if (!stall_in) begin
      for (int k = NSTAGE - 1; k > 0; k--) r_ent[k] <= r_ent[k-1];
      if (w_stall) begin
        // Bubble into EX; the consumer stays in ID and re-evaluates next cycle.
        r_ent[0]  <= '0;
        r_fwd_sel <= '0;
        if (r_stall_cnt != 16'hFFFF) r_stall_cnt <= r_stall_cnt + 16'd1;
      end else begin
        r_ent[0]  <= w_id_ent;
        r_fwd_sel <= w_id_live ? w_sel : '0;
      end
    end
  end

  assign fwd_sel   = r_fwd_sel;
  assign stall_out = w_stall;
  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Scoreboard bench for fwd_hazard_ctrl: directed instruction stream with
// hand-computed expected outputs, checked by a separate monitor each cycle.
module tb_fwd_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        id_valid = 1'b0;
  logic [9:0]  id_rs = '0;
  logic [4:0]  id_rd = '0;
  logic        id_we = 1'b0;
  logic        id_load = 1'b0;
  logic        stall_in = 1'b0;
  logic        flush = 1'b0;
  logic [3:0]  fwd_sel;
  logic        stall_out;
  logic [15:0] stall_cnt;

  always #5 clk = ~clk;

  fwd_hazard_ctrl #(.REG_W(5), .NSRC(2), .NSTAGE(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .id_valid  (id_valid),
    .id_rs     (id_rs),
    .id_rd     (id_rd),
    .id_we     (id_we),
    .id_load   (id_load),
    .stall_in  (stall_in),
    .flush     (flush),
    .fwd_sel   (fwd_sel),
    .stall_out (stall_out),
    .stall_cnt (stall_cnt)
  );

  typedef struct {
    string       name;
    bit          chk;
    logic        st;
    logic [3:0]  sel;
    logic [15:0] cnt;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic void check(string name, string what,
                                logic [15:0] act, logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s %s: got %h expected %h", name, what, act, exp);
  endfunction

  // Drive one ID-cycle of inputs and queue the outputs expected in that cycle.
  task automatic step(input string name, input bit v,
                      input int rs0, input int rs1, input int rd,
                      input bit we, input bit ld, input bit sin,
                      input bit fl, input bit r,
                      input bit est, input int esel, input int ecnt,
                      input bit chk = 1'b1);
    exp_t e;
    @(posedge clk);
    #1;
    rst      = r;
    id_valid = v;
    id_rs    = {5'(rs1), 5'(rs0)};
    id_rd    = 5'(rd);
    id_we    = we;
    id_load  = ld;
    stall_in = sin;
    flush    = fl;
    e.name = name;
    e.chk  = chk;
    e.st   = est;
    e.sel  = 4'(esel);
    e.cnt  = 16'(ecnt);
    sb_q.push_back(e);
  endtask

  // Monitor: one scoreboard entry per cycle, sampled on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        if (e.chk) begin
          $display("[%0t] %-18s stall=%0b sel=%h cnt=%h", $time, e.name,
                   stall_out, fwd_sel, stall_cnt);
          check(e.name, "stall_out", 16'(stall_out), 16'(e.st));
          check(e.name, "fwd_sel",   16'(fwd_sel),   16'(e.sel));
          check(e.name, "stall_cnt", stall_cnt,      e.cnt);
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d entries pending",
             sb_q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    int  c;
    bit  chk;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    //   name                v rs0 rs1 rd we ld sin fl rst  st sel cnt
    step("reset_idle",       0, 0,  0,  0, 0, 0, 0, 0, 0,   0, 0, 0);
    step("add_r3",           1, 1,  2,  3, 1, 0, 0, 0, 0,   0, 0, 0);
    step("sub_uses_r3",      1, 3,  4,  6, 1, 0, 0, 0, 0,   0, 0, 0);
    step("b2b_alu_fwd",      0, 0,  0,  0, 0, 0, 0, 0, 0,   0, 1, 0);
    step("wr_r3",            1, 0,  0,  3, 1, 0, 0, 0, 0,   0, 0, 0);
    step("unrelated",        1, 8,  9,  7, 1, 0, 0, 0, 0,   0, 0, 0);
    step("rd_r3_dist2",      1, 3,  0, 10, 0, 0, 0, 0, 0,   0, 0, 0);
    step("dist2_fwd",        1, 0,  0,  3, 1, 0, 0, 0, 0,   0, 2, 0);
    step("wr_r3_again",      1, 0,  0,  3, 1, 0, 0, 0, 0,   0, 0, 0);
    step("rd_r3_both",       1, 3,  7, 11, 0, 0, 0, 0, 0,   0, 0, 0);
    step("youngest_wins",    0, 0,  0,  0, 0, 0, 0, 0, 0,   0, 1, 0);
    step("lw_r5",            1, 1,  0,  5, 1, 1, 0, 0, 0,   0, 0, 0);
    step("load_use_stall",   1, 1,  5,  6, 1, 0, 0, 0, 0,   1, 0, 0);
    step("load_use_cnt",     1, 1,  5,  6, 1, 0, 0, 0, 0,   0, 0, 1);
    step("load_use_fwd",     0, 0,  0,  0, 0, 0, 0, 0, 0,   0, 8, 1);
    step("lw_r0",            1, 0,  0,  0, 1, 1, 0, 0, 0,   0, 0, 1);
    step("r0_no_stall",      1, 0,  0,  4, 1, 0, 0, 0, 0,   0, 0, 1);
    step("r0_sel_zero",      0, 0,  0,  0, 0, 0, 0, 0, 0,   0, 0, 1);
    step("lw_r5_fwd_r4",     1, 4,  0,  5, 1, 1, 0, 0, 0,   0, 0, 1);
    step("stall_in_hold1",   1, 0,  5,  6, 1, 0, 1, 0, 0,   1, 2, 1);
    step("stall_in_hold2",   1, 0,  5,  6, 1, 0, 1, 0, 0,   1, 2, 1);
    step("stall_in_hold3",   1, 0,  5,  6, 1, 0, 1, 0, 0,   1, 2, 1);
    step("stall_in_release", 1, 0,  5,  6, 1, 0, 0, 0, 0,   1, 2, 1);
    step("after_release",    1, 0,  5,  6, 1, 0, 0, 0, 0,   0, 0, 2);
    step("release_fwd",      0, 0,  0,  0, 0, 0, 0, 0, 0,   0, 8, 2);
    step("lw_r5_b",          1, 0,  0,  5, 1, 1, 0, 0, 0,   0, 0, 2);
    step("flush_no_stall",   1, 0,  5,  6, 1, 0, 0, 1, 0,   0, 0, 2);
    step("flush_bubble",     1, 6,  5,  9, 1, 0, 0, 0, 0,   0, 0, 2);
    step("flush_fwd",        0, 0,  0,  0, 0, 0, 0, 0, 0,   0, 8, 2);
    step("lw_r5_c",          1, 9,  0,  5, 1, 1, 0, 0, 0,   0, 0, 2);
    step("stall_at_rst",     1, 0,  5,  6, 1, 0, 0, 0, 1,   1, 2, 2);
    step("rst_mid_stall",    1, 0,  5,  6, 1, 0, 0, 0, 0,   0, 0, 0);
    step("post_rst_idle",    0, 0,  0,  0, 0, 0, 0, 0, 0,   0, 0, 0);

    // Repeated "lw r5,0(r5)": stalls every other cycle until the counter saturates.
    for (int n = 0; n < 2 * 65537 + 2; n++) begin
      c = n / 2;
      if (c > 65535) c = 65535;
      chk = (n < 8) || (n / 2 >= 65532);
      step("sat_lw_chain", 1, 5, 0, 5, 1, 1, 0, 0, 0,
           (n % 2) == 1, ((n % 2) == 1 && n >= 3) ? 2 : 0, c, chk);
    end
    step("sat_hold",         0, 0,  0,  0, 0, 0, 0, 0, 0,   0, 0, 16'hFFFF);

    repeat (3) @(negedge clk);
    n_checks++;
    if (sb_q.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d pending entries expected 0", sb_q.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
